// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolution stage: B-type condition codes and result record.
package branch_pkg;

    localparam int BR_XLEN = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Registered result; redirect_pc is sized to BR_XLEN, so the stage XLEN must match it.
    typedef struct packed {
        logic               taken;
        logic [BR_XLEN-1:0] redirect_pc;
        logic               mispredict;
        logic               illegal;
    } branch_result_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Valid/ready bus between the issue logic (master) and the branch resolution stage (slave).
interface branch_resolve_unit_if
    import branch_pkg::*;
#(
    parameter int XLEN = BR_XLEN
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic [XLEN-1:0] out_redirect_pc;
    logic            out_mispredict;
    logic            out_illegal;

    modport master (
        output flush, in_valid, funct3, rs1_val, rs2_val, pc, imm, pred_taken, pred_target, out_ready,
        input  in_ready, out_valid, out_taken, out_redirect_pc, out_mispredict, out_illegal
    );

    modport slave (
        input  flush, in_valid, funct3, rs1_val, rs2_val, pc, imm, pred_taken, pred_target, out_ready,
        output in_ready, out_valid, out_taken, out_redirect_pc, out_mispredict, out_illegal
    );
endinterface

// File: rtl/branch_resolve_unit_cond.sv
// Combinational B-type condition evaluator: funct3 and operands to {taken, illegal}.
module branch_cond
    import branch_pkg::*;
#(
    parameter int XLEN = BR_XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            taken,
    output logic            illegal
);

    // Condition decode; 010/011 are reserved encodings and never take the branch.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1_val == rs2_val);
            F3_BNE:  taken = (rs1_val != rs2_val);
            F3_BLT:  taken = ($signed(rs1_val) <  $signed(rs2_val));
            F3_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: taken = (rs1_val <  rs2_val);
            F3_BGEU: taken = (rs1_val >= rs2_val);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution with a one-entry output register and valid/ready handshake.
// Defining BRANCH_STATS_EN adds branch/taken/mispredict counters.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN = BR_XLEN
`ifdef BRANCH_STATS_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_resolve_unit_if.slave bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0]     stat_branches,
    output logic [CNT_W-1:0]     stat_taken,
    output logic [CNT_W-1:0]     stat_mispredict
`endif
);

    logic            cond_taken_s;
    logic            cond_illegal_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] seq_pc_s;
    logic            accept_s;
    branch_result_t  next_s;
    branch_result_t  result_r;
    logic            valid_r;

    branch_cond #(.XLEN(XLEN)) u_cond (
        .funct3  (bus.funct3),
        .rs1_val (bus.rs1_val),
        .rs2_val (bus.rs2_val),
        .taken   (cond_taken_s),
        .illegal (cond_illegal_s)
    );

    assign target_s = bus.pc + bus.imm;
    assign seq_pc_s = bus.pc + XLEN'(4);
    assign accept_s = bus.in_valid && bus.in_ready;

    // Next result; a taken branch with the right direction can still mispredict on target.
    always_comb begin
        next_s             = '0;
        next_s.taken       = cond_taken_s;
        next_s.illegal     = cond_illegal_s;
        next_s.redirect_pc = cond_taken_s ? target_s : seq_pc_s;
        next_s.mispredict  = (cond_taken_s != bus.pred_taken) ||
                             (cond_taken_s && bus.pred_taken && (target_s != bus.pred_target));
    end

    // Holding register: reset beats flush, flush beats accept, a consume clears valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r  <= 1'b0;
            result_r <= '0;
        end else if (bus.flush) begin
            valid_r  <= 1'b0;
            result_r <= result_r;
        end else if (accept_s) begin
            valid_r  <= 1'b1;
            result_r <= next_s;
        end else if (bus.out_ready) begin
            valid_r  <= 1'b0;
            result_r <= result_r;
        end else begin
            valid_r  <= valid_r;
            result_r <= result_r;
        end
    end

    assign bus.in_ready        = !valid_r || bus.out_ready;
    assign bus.out_valid       = valid_r;
    assign bus.out_taken       = result_r.taken;
    assign bus.out_redirect_pc = result_r.redirect_pc;
    assign bus.out_mispredict  = result_r.mispredict;
    assign bus.out_illegal     = result_r.illegal;

`ifdef BRANCH_STATS_EN
    logic             hs_s;
    logic [CNT_W-1:0] branches_r;
    logic [CNT_W-1:0] taken_r;
    logic [CNT_W-1:0] mispredict_r;

    // An entry killed by a same-cycle flush never counts as delivered.
    assign hs_s = valid_r && bus.out_ready && !bus.flush;

    // Statistics counters, wrapping silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            branches_r   <= '0;
            taken_r      <= '0;
            mispredict_r <= '0;
        end else if (hs_s) begin
            branches_r   <= branches_r + CNT_W'(1);
            taken_r      <= taken_r + CNT_W'(result_r.taken);
            mispredict_r <= mispredict_r + CNT_W'(result_r.mispredict);
        end else begin
            branches_r   <= branches_r;
            taken_r      <= taken_r;
            mispredict_r <= mispredict_r;
        end
    end

    assign stat_branches   = branches_r;
    assign stat_taken      = taken_r;
    assign stat_mispredict = mispredict_r;
`endif

endmodule
